// File: rtl/render.sv
// Scene renderer: maps a screen pixel to the RGB888 colour of a car moving over ground and sky.
// Latency: 2 cycles from hcount_in/vcount_in sampling to color_out; car_x steps once per start_in pulse.
// Backpressure: none; one pixel is accepted every cycle and color_out is always driven.
module render #(
   parameter int PIXEL_SCALE = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        start_in,
   output logic [23:0] color_out
);

   localparam logic [23:0] COL_BLACK  = 24'h000000;
   localparam logic [23:0] COL_WHEEL  = 24'h202020;
   localparam logic [23:0] COL_BODY   = 24'hFF0000;
   localparam logic [23:0] COL_GROUND = 24'h228B22;
   localparam logic [23:0] COL_SKY    = 24'h87CEEB;

   localparam logic [10:0] CAR_WRAP   = 11'd640;
   localparam logic [11:0] WHEEL_Y    = 12'd292;
   localparam logic [11:0] WHEEL1_OFS = 12'd8;
   localparam logic [11:0] WHEEL2_OFS = 12'd32;
   localparam logic [11:0] BODY_W     = 12'd40;
   localparam logic [10:0] BODY_Y0    = 11'd268;
   localparam logic [10:0] BODY_Y1    = 11'd284;
   localparam logic [10:0] GROUND_Y   = 11'd300;
   localparam logic [23:0] WHEEL_R2   = 24'd64;

   // Car position state
   logic [9:0]  car_x_q, car_x_d;
   logic [10:0] car_sum;

   // Stage 1 registers: geometry terms derived from the sampled pixel
   logic               active_q, active_d;
   logic               body_q, body_d;
   logic               ground_q, ground_d;
   logic signed [11:0] dx1_q, dx1_d;
   logic signed [11:0] dx2_q, dx2_d;
   logic signed [11:0] dy_q, dy_d;

   // Stage 2 register: final colour
   logic [23:0] color_q, color_d;

   // Stage 1 working signals
   logic [10:0] wx, wy;
   logic [11:0] wx_ext, car_ext;

   // Stage 2 working signals
   logic signed [23:0] dx1_w, dx2_w, dy_w;
   logic [23:0]        dist1, dist2;
   logic               wheel;

   // Car advances two world pixels per start pulse and wraps to the left edge
   always_comb begin
      car_sum = {1'b0, car_x_q} + 11'd2;
      car_x_d = car_x_q;
      if (start_in) begin
         car_x_d = (car_sum >= CAR_WRAP) ? 10'd0 : car_sum[9:0];
      end
   end

   // Stage 1: world coordinates, region flags and wheel offsets, all unwrapped so shapes clip
   always_comb begin
      wx       = 11'(hcount_in >> PIXEL_SCALE);
      wy       = 11'(vcount_in) >> PIXEL_SCALE;
      wx_ext   = {1'b0, wx};
      car_ext  = {2'b00, car_x_q};
      active_d = (hcount_in < 11'd1280) && (vcount_in < 10'd720);
      body_d   = (wx_ext >= car_ext) && (wx_ext < car_ext + BODY_W)
                 && (wy >= BODY_Y0) && (wy < BODY_Y1);
      ground_d = (wy >= GROUND_Y);
      dx1_d    = $signed(wx_ext) - $signed(car_ext + WHEEL1_OFS);
      dx2_d    = $signed(wx_ext) - $signed(car_ext + WHEEL2_OFS);
      dy_d     = $signed({1'b0, wy}) - $signed(WHEEL_Y);
   end

   // Stage 2: wheel distance test and colour priority selection
   always_comb begin
      dx1_w = 24'(dx1_q);
      dx2_w = 24'(dx2_q);
      dy_w  = 24'(dy_q);
      dist1 = $unsigned(dx1_w * dx1_w) + $unsigned(dy_w * dy_w);
      dist2 = $unsigned(dx2_w * dx2_w) + $unsigned(dy_w * dy_w);
      wheel = (dist1 < WHEEL_R2) || (dist2 < WHEEL_R2);
      if (!active_q) begin
         color_d = COL_BLACK;
      end else if (wheel) begin
         color_d = COL_WHEEL;
      end else if (body_q) begin
         color_d = COL_BODY;
      end else if (ground_q) begin
         color_d = COL_GROUND;
      end else begin
         color_d = COL_SKY;
      end
   end

   // Pipeline and car state registers; reset overrides any start pulse
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         car_x_q  <= '0;
         active_q <= 1'b0;
         body_q   <= 1'b0;
         ground_q <= 1'b0;
         dx1_q    <= '0;
         dx2_q    <= '0;
         dy_q     <= '0;
         color_q  <= '0;
      end else begin
         car_x_q  <= car_x_d;
         active_q <= active_d;
         body_q   <= body_d;
         ground_q <= ground_d;
         dx1_q    <= dx1_d;
         dx2_q    <= dx2_d;
         dy_q     <= dy_d;
         color_q  <= color_d;
      end
   end

   assign color_out = color_q;

endmodule

// File: tb/tb_render.sv
// Testbench for render: scoreboard of expected colours checked by an independent monitor.
// Expected colours come from literal values or a plain-arithmetic scene model.
// Each driven pixel is expected on color_out two clock edges after it is sampled.
module tb_render;

   localparam int P = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] h;
   logic [9:0]  v;
   logic        st;
   logic [23:0] col;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] expq[$];
   int          carm = 0;
   logic        issue = 1'b0;
   logic [1:0]  vp;

   always #5 clk = ~clk;

   render #(.PIXEL_SCALE(P)) dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .hcount_in (h),
      .vcount_in (v),
      .start_in  (st),
      .color_out (col)
   );

   // Scene model: colour of screen pixel (hh,vv) with the car at world x = cx
   function automatic logic [23:0] ref_color(input int hh, input int vv, input int cx);
      int wx, wy, d1, d2;
      wx = hh >> P;
      wy = vv >> P;
      if (hh >= 1280 || vv >= 720) return 24'h000000;
      d1 = (wx - (cx + 8)) * (wx - (cx + 8)) + (wy - 292) * (wy - 292);
      d2 = (wx - (cx + 32)) * (wx - (cx + 32)) + (wy - 292) * (wy - 292);
      if (d1 < 64 || d2 < 64) return 24'h202020;
      if (wx >= cx && wx < cx + 40 && wy >= 268 && wy < 284) return 24'hFF0000;
      if (wy >= 300) return 24'h228B22;
      return 24'h87CEEB;
   endfunction

   // Tracks which cycles carry an issued pixel through the 2-cycle latency
   always @(posedge clk or posedge rst) begin
      if (rst) vp <= 2'b00;
      else     vp <= {vp[0], issue};
   end

   // Monitor: pops one expectation for each pixel emerging from the DUT
   always @(negedge clk) begin
      logic [23:0] e;
      if (!rst && vp[1]) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL pop_empty: color_out=%h with no expected pixel queued", col);
         end else begin
            e = expq.pop_front();
            if (col !== e) begin
               errors++;
               $display("FAIL pixel: color_out=%h expected=%h (t=%0t)", col, e, $time);
            end
         end
      end
   end

   task automatic px(input int hh, input int vv, input bit s,
                     input bit use_lit, input logic [23:0] lit);
      @(posedge clk);
      #1;
      h     = 11'(hh);
      v     = 10'(vv);
      st    = s;
      issue = 1'b1;
      expq.push_back(use_lit ? lit : ref_color(hh, vv, carm));
      if (s) carm = (carm + 2 >= 640) ? 0 : carm + 2;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         issue = 1'b0;
         st    = 1'b0;
      end
   endtask

   task automatic drain();
      int k;
      idle(3);
      k = 0;
      while (expq.size() != 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d pixels never emerged, required 0", expq.size());
         expq.delete();
      end
   endtask

   initial begin
      int hh, vv;
      rst = 1'b1;
      h   = '0;
      v   = '0;
      st  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (col !== 24'h000000) begin
         errors++;
         $display("FAIL reset_color: color_out=%h expected=000000", col);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic regions
      px(100, 100, 0, 1, 24'h87CEEB);
      px(0, 600, 0, 1, 24'h228B22);
      px(1280, 0, 0, 1, 24'h000000);
      px(0, 720, 0, 1, 24'h000000);
      // Car at 0: body, wheel centre, just past body
      px(40, 540, 0, 1, 24'hFF0000);
      px(16, 584, 0, 1, 24'h202020);
      px(80, 540, 0, 1, 24'h87CEEB);
      // One start pulse moves car to 2
      px(1280, 720, 1, 1, 24'h000000);
      px(0, 540, 0, 1, 24'h87CEEB);
      px(4, 540, 0, 1, 24'hFF0000);
      px(100, 100, 0, 1, 24'h87CEEB);
      drain();

      // Mid-frame reset with start held high: output clears at once, car returns to 0
      @(posedge clk);
      #3;
      st  = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (col !== 24'h000000) begin
         errors++;
         $display("FAIL midframe_reset: color_out=%h expected=000000", col);
      end
      carm = 0;
      expq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      st  = 1'b0;
      px(40, 540, 0, 1, 24'hFF0000);
      px(4, 540, 0, 1, 24'hFF0000);

      // 320 pulses bring the car back to 0
      for (int i = 0; i < 320; i++) px(40 + 2 * i, 540, 1, 0, 24'h0);
      px(40, 540, 0, 1, 24'hFF0000);
      px(0, 540, 0, 1, 24'hFF0000);
      drain();

      // Randomised pixels, half of them near the car
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            hh = $urandom_range(0, 1649);
            vv = $urandom_range(0, 749);
         end else begin
            hh = (carm << P) + $urandom_range(0, 100);
            vv = $urandom_range(520, 620);
         end
         px(hh, vv, ($urandom_range(0, 7) == 0), 0, 24'h0);
      end
      drain();

      // Frame sweeps over the body and wheel lines, one start per frame
      for (int f = 0; f < 5; f++) begin
         for (int hx = 0; hx < 1650; hx++) px(hx, 540, 0, 0, 24'h0);
         for (int hx = 0; hx < 1650; hx++) px(hx, 584, 0, 0, 24'h0);
         px(1280, 720, 1, 0, 24'h0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, required completion before 2000000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/render.md
RENDER -- requirements
Module: render

Interface
REQ-001 SHALL have parameter PIXEL_SCALE, default 1, meaning the log2 zoom: world coordinate = screen coordinate >> PIXEL_SCALE; legal values 0..3.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port hcount_in, input, 11 bits: horizontal screen pixel counter, 0..1649, active region 0..1279.
REQ-005 SHALL have port vcount_in, input, 10 bits: vertical screen line counter, 0..749, active region 0..719.
REQ-006 SHALL have port start_in, input, 1 bit: one-cycle pulse once per frame that advances the animation.
REQ-007 SHALL have port color_out, output, 24 bits: RGB888 pixel colour, {R[23:16],G[15:8],B[7:0]}.

Function
REQ-008 SHALL form world coordinates wx = hcount_in >> PIXEL_SCALE and wy = vcount_in >> PIXEL_SCALE, both unsigned 11-bit.
REQ-009 SHALL hold an internal car position car_x, unsigned 10-bit, in the range 0..638.
REQ-010 SHALL, on each clock with start_in=1, set car_x to car_x+2, or to 0 when car_x+2 >= 640.
REQ-011 SHALL give the pixel as active only when hcount_in < 1280 and vcount_in < 720; an inactive pixel outputs colour 0x000000.
REQ-012 SHALL output wheel colour 0x202020 when the pixel is active and inside either wheel.
REQ-013 SHALL define each wheel as a disc with centre (car_x+8, 292) or (car_x+32, 292), inside when dx*dx+dy*dy < 64.
REQ-014 SHALL compute dx and dy as signed 12-bit values and the sum of squares as unsigned 24-bit, with no overflow or wrap.
REQ-015 SHALL otherwise output body colour 0xFF0000 when car_x <= wx < car_x+40 and 268 <= wy < 284.
REQ-016 SHALL otherwise output ground colour 0x228B22 when wy >= 300.
REQ-017 SHALL otherwise output sky colour 0x87CEEB.
REQ-018 SHALL apply colour priority: inactive > wheel > body > ground > sky.
REQ-019 SHALL clip shapes at the world right edge; geometry SHALL NOT wrap horizontally.
REQ-020 SHALL be a two-stage pipeline with 2 cycles latency: colour_out at edge N+2 reflects hcount_in/vcount_in sampled at edge N.
REQ-021 SHALL use in stage 1 the car_x value present at that sampling edge; a start_in pulse affects pixels sampled on later edges.
REQ-022 SHALL NOT use start_in for any other purpose; hcount_in and vcount_in are taken as-is, with no synchronisation checks.

Reset
REQ-023 SHALL, while rst_in=1, force car_x=0, clear all pipeline registers, and force color_out=0x000000.
REQ-024 SHALL let reset win over a simultaneous start_in.
REQ-025 SHALL produce valid colour for the first pixel 2 clocks after rst_in deasserts.

Verification (PIXEL_SCALE=1)
REQ-026 SHALL pass: assert rst_in mid-frame -> color_out=0x000000 at once and car_x=0.
REQ-027 SHALL pass: after reset, drive h=100, v=100 -> color_out=0x87CEEB two cycles later; h=0, v=600 -> 0x228B22; h=1280, v=0 -> 0x000000; h=0, v=720 -> 0x000000.
REQ-028 SHALL pass: car_x=0, drive h=40, v=540 -> 0xFF0000; h=16, v=584 -> 0x202020; h=80, v=540 -> 0x87CEEB.
REQ-029 SHALL pass: one start_in pulse (car_x=2), drive h=0, v=540 -> 0x87CEEB; h=4, v=540 -> 0xFF0000.
REQ-030 SHALL pass: 320 start_in pulses -> car_x wraps to 0 and h=40, v=540 -> 0xFF0000 again.
REQ-031 SHALL pass: full-frame sweep of 5 frames with start_in at (1280, 720) -> no X on color_out, and body moves 2 world px per frame.
